stream_source: RTL and testbench

- Cycle-accurate AXI-stream traffic source. It is the transmitter that drives the write side (TVALID/TREADY/TDATA) of the FWFT stream FIFOs.
- On a command it emits a burst of count words: base, base+stride, base+2*stride, ...
- It marks the final beat with TLAST and pulses done.
- Used in kernels and testbenches to feed FIFO chains under backpressure.

---
 rtl/stream_source_pkg.sv | 16 +
 rtl/stream_source_ctr.sv | 27 ++
 rtl/stream_source.sv | 138 +++++++++++++
 tb/tb_stream_source.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_source_pkg.sv
// Shared types and default widths for the stream_source traffic generator.
// The STREAM_SOURCE_GAP_EN build makes the GAP state reachable.
package stream_source_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int GAP_WIDTH      = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/stream_source_ctr.sv
// Loadable down-counter with last/zero flags; used for the remaining beats
// and for the inter-beat gap.
module stream_source_ctr
    import stream_source_pkg::*;
#(
    parameter int W = DEF_CNT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         is_last,
    output logic         is_zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec)  cnt <= cnt - W'(1);
    end

    assign is_last = (cnt == W'(1));
    assign is_zero = (cnt == '0);

endmodule

// File: rtl/stream_source.sv
// AXI-stream burst source: emits base, base+stride, ... for count beats, TLAST on
// the final beat, then a one-cycle done. STREAM_SOURCE_GAP_EN adds cmd_gap idle cycles.
module stream_source
    import stream_source_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_TVALID,
    output logic                  cmd_TREADY,
    input  logic [DATA_WIDTH-1:0] cmd_base,
    input  logic [DATA_WIDTH-1:0] cmd_stride,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
`ifdef STREAM_SOURCE_GAP_EN
    input  logic [GAP_WIDTH-1:0]  cmd_gap,
`endif
    output logic                  dout_TVALID,
    input  logic                  dout_TREADY,
    output logic [DATA_WIDTH-1:0] dout_TDATA,
    output logic                  dout_TLAST,
    output logic                  busy,
    output logic                  done
);

    state_t                state;
    logic [DATA_WIDTH-1:0] stride_q;
    logic                  cmd_fire, beat_fire, rem_dec;
    logic [CNT_WIDTH-1:0]  rem_cnt;
    logic                  rem_is_last, rem_is_zero;
    logic                  unused_flags;

    assign cmd_TREADY = (state == IDLE);
    assign cmd_fire   = cmd_TVALID && cmd_TREADY;
    assign beat_fire  = (state == RUN) && dout_TVALID && dout_TREADY;
    // The last beat needs no decrement; the burst ends on its accept.
    assign rem_dec    = beat_fire && !dout_TLAST;

    stream_source_ctr #(.W(CNT_WIDTH)) u_rem (
        .clk      (clk),
        .rst      (reset),
        .load     (cmd_fire),
        .load_val (cmd_count),
        .dec      (rem_dec),
        .cnt      (rem_cnt),
        .is_last  (rem_is_last),
        .is_zero  (rem_is_zero)
    );

`ifdef STREAM_SOURCE_GAP_EN
    logic [GAP_WIDTH-1:0] gap_q, gap_cnt;
    logic                 gap_is_last, gap_is_zero;

    // Loaded with gap-1 so that is_zero marks the final idle cycle.
    stream_source_ctr #(.W(GAP_WIDTH)) u_gap (
        .clk      (clk),
        .rst      (reset),
        .load     (rem_dec && (gap_q != '0)),
        .load_val (gap_q - GAP_WIDTH'(1)),
        .dec      (state == GAP),
        .cnt      (gap_cnt),
        .is_last  (gap_is_last),
        .is_zero  (gap_is_zero)
    );

    assign unused_flags = ^{rem_is_zero, gap_cnt, gap_is_last};
`else
    assign unused_flags = ^{rem_is_last, rem_is_zero};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            stride_q    <= '0;
            dout_TVALID <= 1'b0;
            dout_TDATA  <= '0;
            dout_TLAST  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef STREAM_SOURCE_GAP_EN
            gap_q       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cmd_fire) begin
                    stride_q   <= cmd_stride;
                    dout_TDATA <= cmd_base;
                    busy       <= 1'b1;
`ifdef STREAM_SOURCE_GAP_EN
                    gap_q      <= cmd_gap;
`endif
                    if (cmd_count == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state       <= RUN;
                        dout_TVALID <= 1'b1;
                        dout_TLAST  <= (cmd_count == CNT_WIDTH'(1));
                    end
                end
                RUN: if (beat_fire) begin
                    if (dout_TLAST) begin
                        dout_TVALID <= 1'b0;
                        dout_TLAST  <= 1'b0;
                        state       <= DONE;
                        done        <= 1'b1;
                    end else begin
                        dout_TDATA <= dout_TDATA + stride_q;
`ifdef STREAM_SOURCE_GAP_EN
                        if (gap_q != '0) begin
                            dout_TVALID <= 1'b0;
                            state       <= GAP;
                        end
                        dout_TLAST <= (gap_q == '0) && (rem_cnt == CNT_WIDTH'(2));
`else
                        dout_TLAST <= (rem_cnt == CNT_WIDTH'(2));
`endif
                    end
                end
`ifdef STREAM_SOURCE_GAP_EN
                GAP: if (gap_is_zero) begin
                    state       <= RUN;
                    dout_TVALID <= 1'b1;
                    dout_TLAST  <= rem_is_last;
                end
`endif
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_source.sv
// Self-checking bench for stream_source: bursts are compared against a
// reference list base + i*stride built from the command fields.
module tb_stream_source;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_TVALID, cmd_TREADY;
    logic [DW-1:0] cmd_base, cmd_stride;
    logic [CW-1:0] cmd_count;
    logic [7:0]    cmd_gap;
    logic          dout_TVALID, dout_TREADY, dout_TLAST, busy, done;
    logic [DW-1:0] dout_TDATA;

    int checks = 0;
    int errors = 0;

    stream_source #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_TVALID  (cmd_TVALID),
        .cmd_TREADY  (cmd_TREADY),
        .cmd_base    (cmd_base),
        .cmd_stride  (cmd_stride),
        .cmd_count   (cmd_count),
`ifdef STREAM_SOURCE_GAP_EN
        .cmd_gap     (cmd_gap),
`endif
        .dout_TVALID (dout_TVALID),
        .dout_TREADY (dout_TREADY),
        .dout_TDATA  (dout_TDATA),
        .dout_TLAST  (dout_TLAST),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Observations of the most recent burst (t = negedges after the accept edge)
    logic [DW-1:0] obs_data[$];
    bit            obs_last[$];
    int            obs_t[$];
    int            done_t, done_cnt, stall_err, vld_cnt;
    logic [63:0]   vpat;
    logic          busy_after_done, busy_t1, rdy_t1, rdy_issue;

    function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] base, input logic [DW-1:0] stride, input int i);
        logic [63:0] full;
        full = 64'(base) + 64'(i) * 64'(stride);
        return full[DW-1:0];
    endfunction

    // Issues one command and records the burst; mode 0 ready, 1 fixed toggle, 2 random
    task automatic collect(input logic [DW-1:0] base, input logic [DW-1:0] stride,
                           input logic [CW-1:0] count, input int mode, input int maxcyc,
                           input bit no_wait);
        bit [5:0]      pat = 6'b101001;
        bit            pv_stall, r;
        logic [DW-1:0] pdata;
        logic          plast;
        obs_data.delete(); obs_last.delete(); obs_t.delete();
        done_t = -1; done_cnt = 0; stall_err = 0; vld_cnt = 0; vpat = '0;
        busy_after_done = 1'bx; pdata = '0; plast = 1'b0; pv_stall = 1'b0;
        if (!no_wait) @(negedge clk);
        rdy_issue   = cmd_TREADY;
        cmd_TVALID  = 1'b1;
        cmd_base    = base;
        cmd_stride  = stride;
        cmd_count   = count;
        dout_TREADY = 1'b0;
        @(negedge clk);
        cmd_TVALID = 1'b0;
        cmd_base   = $urandom;
        cmd_stride = $urandom;
        cmd_count  = CW'($urandom);
        for (int t = 1; t < maxcyc; t++) begin
            if (t == 1) begin busy_t1 = busy; rdy_t1 = cmd_TREADY; end
            if (t < 64) vpat[t] = dout_TVALID;
            if (dout_TVALID) vld_cnt++;
            if (done) begin done_cnt++; if (done_t < 0) done_t = t; end
            if (done_t >= 0 && t == done_t + 1) busy_after_done = busy;
            if (pv_stall && (dout_TVALID !== 1'b1 || dout_TDATA !== pdata || dout_TLAST !== plast))
                stall_err++;
            case (mode)
                0:       r = 1'b1;
                1:       r = pat[(t-1) % 6];
                default: r = 1'($urandom_range(0, 1));
            endcase
            dout_TREADY = r;
            if (dout_TVALID && r) begin
                obs_data.push_back(dout_TDATA);
                obs_last.push_back(dout_TLAST);
                obs_t.push_back(t);
            end
            pv_stall = dout_TVALID && !r;
            pdata    = dout_TDATA;
            plast    = dout_TLAST;
            if (done_t >= 0 && t >= done_t + 2) break;
            @(negedge clk);
        end
        dout_TREADY = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; cmd_TVALID = 1'b0; dout_TREADY = 1'b0;
        cmd_base = '0; cmd_stride = '0; cmd_count = '0; cmd_gap = '0;
        #12;
        checks++;
        if ({dout_TVALID, dout_TLAST, busy, done, cmd_TREADY} !== 5'b00001 || dout_TDATA !== '0) begin
            errors++;
            $display("FAIL reset_during: vld/last/busy/done/rdy=%b data=%h required 00001 data=0",
                     {dout_TVALID, dout_TLAST, busy, done, cmd_TREADY}, dout_TDATA);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({dout_TVALID, dout_TLAST, busy, done, cmd_TREADY} !== 5'b00001 || dout_TDATA !== '0) begin
            errors++;
            $display("FAIL reset_after: vld/last/busy/done/rdy=%b data=%h required 00001 data=0",
                     {dout_TVALID, dout_TLAST, busy, done, cmd_TREADY}, dout_TDATA);
        end
    endtask

    task automatic test_basic;
        collect(32'h10, 32'd1, 16'd4, 0, 40, 1'b0);
        checks++;
        if (obs_data.size() != 4) begin
            errors++; $display("FAIL basic_beats: got %0d required 4", obs_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_data[i] !== 32'h10 + 32'(i) || obs_last[i] !== (i == 3) || obs_t[i] != i + 1) begin
                    errors++;
                    $display("FAIL basic_beat%0d: data=%h last=%b t=%0d required %h %b %0d",
                             i, obs_data[i], obs_last[i], obs_t[i], 32'h10 + 32'(i), i == 3, i + 1);
                end
            end
        end
        checks++;
        if (done_t != 5 || done_cnt != 1 || busy_after_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done_t=%0d cnt=%0d busy_after=%b required 5 1 0",
                     done_t, done_cnt, busy_after_done);
        end
        checks++;
        if (busy_t1 !== 1'b1 || rdy_t1 !== 1'b0 || rdy_issue !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%b cmd_rdy=%b issue_rdy=%b required 1 0 1",
                     busy_t1, rdy_t1, rdy_issue);
        end
    endtask

    task automatic test_backpressure;
        collect(32'd0, 32'd3, 16'd3, 1, 40, 1'b0);
        checks++;
        if (obs_data.size() != 3 || stall_err != 0) begin
            errors++;
            $display("FAIL bp_count: beats=%0d stall_err=%0d required 3 0", obs_data.size(), stall_err);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_data[i] !== 32'(3 * i) || obs_last[i] !== (i == 2)) begin
                    errors++;
                    $display("FAIL bp_beat%0d: data=%h last=%b required %h %b",
                             i, obs_data[i], obs_last[i], 32'(3 * i), i == 2);
                end
            end
            checks++;
            if (obs_t[0] != 1 || obs_t[1] != 4 || obs_t[2] != 6 || done_t != 7) begin
                errors++;
                $display("FAIL bp_timing: t=%0d,%0d,%0d done=%0d required 1,4,6 done=7",
                         obs_t[0], obs_t[1], obs_t[2], done_t);
            end
        end
    endtask

    task automatic test_zero_count;
        collect(32'hABCD, 32'd5, 16'd0, 0, 20, 1'b0);
        checks++;
        if (vld_cnt != 0 || done_t != 1 || done_cnt != 1 || busy_after_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_count: vld=%0d done_t=%0d cnt=%0d busy_after=%b required 0 1 1 0",
                     vld_cnt, done_t, done_cnt, busy_after_done);
        end
    endtask

    task automatic test_wrap;
        collect(32'hFFFF_FFFE, 32'd1, 16'd3, 0, 20, 1'b0);
        checks++;
        if (obs_data.size() != 3) begin
            errors++; $display("FAIL wrap_beats: got %0d required 3", obs_data.size());
        end else begin
            checks++;
            if (obs_data[0] !== 32'hFFFF_FFFE || obs_data[1] !== 32'hFFFF_FFFF ||
                obs_data[2] !== 32'h0 || obs_last[2] !== 1'b1 || obs_last[1] !== 1'b0) begin
                errors++;
                $display("FAIL wrap_data: %h %h %h last2=%b required fffffffe ffffffff 00000000 1",
                         obs_data[0], obs_data[1], obs_data[2], obs_last[2]);
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 10; n++) begin
            logic [DW-1:0] b, s;
            int            c, bad;
            b = $urandom; s = $urandom;
            c = (n == 3) ? 0 : int'($urandom_range(1, 12));
            collect(b, s, CW'(c), 2, 200, 1'b0);
            bad = 0;
            if (obs_data.size() != c) bad++;
            else for (int i = 0; i < c; i++)
                if (obs_data[i] !== exp_word(b, s, i) || obs_last[i] !== (i == c - 1)) bad++;
            checks++;
            if (bad != 0 || stall_err != 0 || done_cnt != 1) begin
                errors++;
                $display("FAIL rand%0d: count=%0d beats=%0d bad=%0d stall_err=%0d done_cnt=%0d",
                         n, c, obs_data.size(), bad, stall_err, done_cnt);
            end
            checks++;
            if (c > 0 && obs_t.size() == c && done_t != obs_t[c-1] + 1) begin
                errors++;
                $display("FAIL rand%0d_done: done_t=%0d required %0d", n, done_t, obs_t[c-1] + 1);
            end
        end
    endtask

    task automatic test_mid_reset;
        bit saw_done = 1'b0;
        @(negedge clk);
        cmd_TVALID = 1'b1; cmd_base = 32'h100; cmd_stride = 32'h4; cmd_count = 16'd8;
        @(negedge clk);
        cmd_TVALID = 1'b0; dout_TREADY = 1'b1;
        @(negedge clk);
        dout_TREADY = 1'b0;
        checks++;
        if (dout_TVALID !== 1'b1 || dout_TDATA !== 32'h104) begin
            errors++;
            $display("FAIL mreset_pre: vld=%b data=%h required 1 00000104", dout_TVALID, dout_TDATA);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (dout_TVALID !== 1'b0 || dout_TLAST !== 1'b0 || cmd_TREADY !== 1'b1) begin
            errors++;
            $display("FAIL mreset_async: vld=%b last=%b rdy=%b required 0 0 1",
                     dout_TVALID, dout_TLAST, cmd_TREADY);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        reset = 1'b0;
        collect(32'h55, 32'h2, 16'd2, 0, 20, 1'b1);
        checks++;
        if (saw_done || rdy_issue !== 1'b1 || obs_data.size() != 2 || done_t != 3) begin
            errors++;
            $display("FAIL mreset_after: done_in_reset=%b rdy=%b beats=%0d done_t=%0d required 0 1 2 3",
                     saw_done, rdy_issue, obs_data.size(), done_t);
        end else begin
            checks++;
            if (obs_data[0] !== 32'h55 || obs_data[1] !== 32'h57 || obs_last[1] !== 1'b1) begin
                errors++;
                $display("FAIL mreset_data: %h %h last=%b required 00000055 00000057 1",
                         obs_data[0], obs_data[1], obs_last[1]);
            end
        end
    endtask

    task automatic test_max_count;
        collect(32'h7, 32'h3, 16'hFFFF, 0, 65600, 1'b0);
        checks++;
        if (obs_data.size() != 65535 || done_t != 65536) begin
            errors++;
            $display("FAIL max_count: beats=%0d done_t=%0d required 65535 65536", obs_data.size(), done_t);
        end else begin
            checks++;
            if (obs_data[65534] !== exp_word(32'h7, 32'h3, 65534) || obs_last[65534] !== 1'b1 ||
                obs_last[65533] !== 1'b0) begin
                errors++;
                $display("FAIL max_last: data=%h last=%b required %h 1",
                         obs_data[65534], obs_last[65534], exp_word(32'h7, 32'h3, 65534));
            end
        end
    endtask

`ifdef STREAM_SOURCE_GAP_EN
    task automatic test_gap;
        cmd_gap = 8'd2;
        collect(32'h20, 32'h1, 16'd3, 0, 40, 1'b0);
        cmd_gap = 8'd0;
        checks++;
        if (vpat[7:1] !== 7'b1001001 || obs_data.size() != 3 || done_t != 8) begin
            errors++;
            $display("FAIL gap_pattern: vpat=%b beats=%0d done_t=%0d required 1001001 3 8",
                     vpat[7:1], obs_data.size(), done_t);
        end else begin
            checks++;
            if (obs_last[2] !== 1'b1 || obs_last[0] !== 1'b0 || obs_last[1] !== 1'b0 || obs_data[2] !== 32'h22) begin
                errors++;
                $display("FAIL gap_last: last=%b%b%b data2=%h required 001 00000022",
                         obs_last[0], obs_last[1], obs_last[2], obs_data[2]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_wrap();
        test_random();
        test_mid_reset();
`ifdef STREAM_SOURCE_GAP_EN
        test_gap();
`endif
        test_max_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
